// File: rtl/modulador_pkg.sv
// Shared definitions for the modulador block: FSM state encoding, the
// modulation mode encoding on mode_i, and the per-sample phase steps.
package modulador_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Encoding of mode_i, latched together with the word.
  localparam logic MODE_FSK  = 1'b0;
  localparam logic MODE_BPSK = 1'b1;

  // Phase increments per sample: a full carrier cycle per bit advances by 2,
  // a half cycle per bit advances by 1 (table holds two cycles' worth of steps).
  localparam int STEP_FULL_CYCLE = 2;
  localparam int STEP_HALF_CYCLE = 1;

endpackage

// File: rtl/modulador_sine_lut.sv
// Combinational sine table for the modulator carrier.
// N = 2^(SPB_LOG2+1) entries, entry k = round(M + M*sin(2*pi*k/N)) with
// M = 2^(SAMP_W-1), saturated to the unsigned range of SAMP_W bits.
// Contents are computed at elaboration with a real-valued Taylor series.
module modulador_sine_lut #(
  parameter int SPB_LOG2 = 5,
  parameter int SAMP_W   = 8
) (
  input  logic [SPB_LOG2:0]  idx,
  output logic [SAMP_W-1:0]  sample
);

  localparam int N = 2 ** (SPB_LOG2 + 1);

  // sin(x) for x already reduced to [-pi, pi]; the series converges well there.
  function automatic real sine_series(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Round half up and clamp into [0, 2^SAMP_W-1].
  function automatic int round_sat(input real v);
    int r;
    int top;
    top = (1 << SAMP_W) - 1;
    if (v < 0.0) begin
      r = 0;
    end else begin
      r = $rtoi(v + 0.5);
    end
    if (r > top) r = top;
    return r;
  endfunction

  function automatic int sine_entry(input int k);
    real pi;
    real ang;
    real mid;
    pi  = 3.14159265358979323846;
    mid = real'(1 << (SAMP_W - 1));
    ang = 2.0 * pi * real'(k) / real'(N);
    if (ang > pi) ang = ang - 2.0 * pi;
    return round_sat(mid + mid * sine_series(ang));
  endfunction

  logic [SAMP_W-1:0] rom [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam int ENTRY = sine_entry(k);
    assign rom[k] = ENTRY[SAMP_W-1:0];
  end

  assign sample = rom[idx];

endmodule

// File: rtl/modulador_param.sv
// Word-serial FSK / BPSK carrier modulator.
// Accepts a DATA_W-bit word with a ready/valid handshake and emits
// 2^SPB_LOG2 unsigned carrier samples per bit. Mode 0 is continuous-phase
// FSK (bit 0: one carrier cycle per bit, bit 1: half a cycle), mode 1 is
// BPSK (one cycle per bit, bit 1 shifted by half a turn).
// Build option: define MODULADOR_MSB_FIRST_EN to serialise MSB first
// (LSB first otherwise).
module modulador_param
  import modulador_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int SAMP_W   = 8,
  parameter int SPB_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  input  logic              mode_i,
  output logic [SAMP_W-1:0] sample_o,
  output logic              sample_valid_o,
  output logic              busy_o,
  output logic              word_done_o
);

  localparam int PH_W  = SPB_LOG2 + 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [SPB_LOG2-1:0] SAMP_LAST = '1;
  localparam logic [PH_W-1:0]     HALF_TURN = {1'b1, {SPB_LOG2{1'b0}}};
  localparam logic [SAMP_W-1:0]   SAMP_MID  = {1'b1, {(SAMP_W-1){1'b0}}};

  // Bit position within the word for a given bit count.
  function automatic logic [BIT_W-1:0] bit_pos(input logic [BIT_W-1:0] cnt);
`ifdef MODULADOR_MSB_FIRST_EN
    return BIT_LAST - cnt;
`else
    return cnt;
`endif
  endfunction

  // Phase advance per sample for the bit currently on air.
  function automatic logic [PH_W-1:0] phase_step(input logic mode, input logic bitv);
    if (mode == MODE_FSK && bitv) begin
      return PH_W'(STEP_HALF_CYCLE);
    end
    return PH_W'(STEP_FULL_CYCLE);
  endfunction

  state_t              state, state_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [SPB_LOG2-1:0] samp_cnt, samp_nxt;
  logic [PH_W-1:0]     phase, phase_nxt;
  logic [DATA_W-1:0]   word_q, word_nxt;
  logic                mode_q, mode_nxt;

  logic                accept;
  logic                last_sample;
  logic                cur_bit;
  logic                nxt_bit;
  logic [PH_W-1:0]     lut_idx;
  logic [SAMP_W-1:0]   lut_sample;
  logic [SAMP_W-1:0]   sample_nxt;
  logic                vld_nxt;
  logic                done_nxt;

  assign last_sample  = (state == ST_SEND) && (samp_cnt == SAMP_LAST) && (bit_cnt == BIT_LAST);
  assign data_ready_o = (state == ST_IDLE) || last_sample;
  assign accept       = data_valid_i && data_ready_o;
  assign busy_o       = (state == ST_SEND);
  assign cur_bit      = word_q[bit_pos(bit_cnt)];

  // Next-state: counters/phase describe the sample shown after the next edge.
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    samp_nxt  = samp_cnt;
    phase_nxt = phase;
    word_nxt  = word_q;
    mode_nxt  = mode_q;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_SEND;
          word_nxt  = data_i;
          mode_nxt  = mode_i;
          bit_nxt   = '0;
          samp_nxt  = '0;
          phase_nxt = '0;
        end
      end
      ST_SEND: begin
        if (last_sample) begin
          bit_nxt  = '0;
          samp_nxt = '0;
          if (accept) begin
            // Back-to-back word: carrier phase continues without a jump.
            word_nxt  = data_i;
            mode_nxt  = mode_i;
            phase_nxt = phase + phase_step(mode_q, cur_bit);
          end else begin
            state_nxt = ST_IDLE;
            phase_nxt = '0;
          end
        end else begin
          samp_nxt  = samp_cnt + 1'b1;
          phase_nxt = phase + phase_step(mode_q, cur_bit);
          if (samp_cnt == SAMP_LAST) begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Table lookup for the upcoming sample, BPSK adds half a turn for a 1 bit.
  always_comb begin
    nxt_bit = word_nxt[bit_pos(bit_nxt)];
    lut_idx = phase_nxt;
    if (mode_nxt == MODE_BPSK && nxt_bit) begin
      lut_idx = phase_nxt + HALF_TURN;
    end
    vld_nxt    = (state_nxt == ST_SEND);
    sample_nxt = vld_nxt ? lut_sample : SAMP_MID;
    done_nxt   = vld_nxt && (samp_nxt == SAMP_LAST) && (bit_nxt == BIT_LAST);
  end

  modulador_sine_lut #(
    .SPB_LOG2 (SPB_LOG2),
    .SAMP_W   (SAMP_W)
  ) u_sine_lut (
    .idx    (lut_idx),
    .sample (lut_sample)
  );

  // Control state, counters, phase and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      bit_cnt        <= '0;
      samp_cnt       <= '0;
      phase          <= '0;
      sample_o       <= SAMP_MID;
      sample_valid_o <= 1'b0;
      word_done_o    <= 1'b0;
    end else begin
      state          <= state_nxt;
      bit_cnt        <= bit_nxt;
      samp_cnt       <= samp_nxt;
      phase          <= phase_nxt;
      sample_o       <= sample_nxt;
      sample_valid_o <= vld_nxt;
      word_done_o    <= done_nxt;
    end
  end

  // Latched word and mode; only meaningful while a word is on air.
  always_ff @(posedge clk) begin
    word_q <= word_nxt;
    mode_q <= mode_nxt;
  end

endmodule
